cdr_dlf_lock: RTL
=================

Name: cdr_dlf_lock

Overview:
Parametrised second-order digital loop filter for the RX CDR, with a built-in lock detector. It consumes early/late votes from the bang-bang phase detector and drives the phase-interpolator code, using a proportional path plus a saturating frequency integrator. Code wrap-around (rotator mode) or clamping is selectable. The lock detector monitors windowed vote balance with hysteresis. Its `locked` output feeds downstream alignment logic.

Parameters:
- CODE_W, 11, PI code width.
- FRAC_W, 8, fractional bits below the code in the phase accumulator.
- FREQ_W, 16, signed frequency-integrator width.
- KP, 4, proportional gain in code LSBs per vote (unsigned, >=0).
- KI, 1, integral gain in fractional LSBs per vote (unsigned, >=0).
- WRAP, 1, 1 = code wraps modulo 2^CODE_W; 0 = saturate at 0 / 2^CODE_W-1.
- CODE_INIT, 0, reset value of code.
- WIN_LEN, 64, lock-detector window length in counted cycles.
- LOCK_THR, 4, |net votes| <= this counts as a good window.
- UNLOCK_THR, 16, |net votes| > this drops lock.
- LOCK_WINDOWS, 4, consecutive good windows required to assert lock.

Ports:
- clk, in, 1, recovered/PI clock.
- rst, in, 1, synchronous reset, active-high.
- up, in, 1, BBPD early vote.
- dn, in, 1, BBPD late vote.
- freeze, in, 1, hold all loop and lock state.
- code, out, CODE_W, PI code.
- freq_int, out, FREQ_W signed, frequency integrator value.
- locked, out, 1, lock status.
- win_done, out, 1, one-cycle pulse at each window end.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`; `rst` has priority over all other inputs.
- Reset values:
  - phase_acc = CODE_INIT << FRAC_W, so code = CODE_INIT.
  - freq_int = 0; locked = 0; win_done = 0.
  - Window counter, net-vote sum and good-window count = 0.
- Vote decode: pd = +1 if up&!dn, -1 if dn&!up, 0 if both or neither.
- Per cycle, when freeze=0:
  - freq_int <= sat(freq_int + pd*KI), saturating to ±(2^(FREQ_W-1)-1).
  - phase_acc <= phase_acc + pd*(KP<<FRAC_W) + sext(freq_int), where freq_int is the current registered value, not the updated one.
- Arithmetic is performed at CODE_W+FRAC_W+2 bits.
  - WRAP=1: the result is taken modulo 2^(CODE_W+FRAC_W).
  - WRAP=0: the result clamps to [0, 2^(CODE_W+FRAC_W)-1].
- code = phase_acc[CODE_W+FRAC_W-1:FRAC_W]. Latency is one cycle from up/dn to code.
- freeze=1: phase_acc, freq_int, window counter, sum and good count all hold; locked holds; win_done = 0.
- Lock detector (sub-module):
  - Counts cycles 0..WIN_LEN-1 and accumulates a signed sum of pd (width clog2(WIN_LEN)+2).
  - On the last cycle of a window: win_done=1 for that cycle; evaluate s = |sum including that cycle's pd|; clear sum and counter.
  - If s <= LOCK_THR: good count increments, saturating at LOCK_WINDOWS.
  - If s > LOCK_THR: good count is cleared.
  - If locked=0 and good count reaches LOCK_WINDOWS: locked=1 at the next clock edge.
  - If locked=1 and s > UNLOCK_THR: locked=0.
  - If LOCK_THR < s <= UNLOCK_THR while locked: locked stays 1 and the good count is cleared.
- Reset mid-operation returns every output to its reset value at the next edge; no partial window is carried over.

Decomposition:
- Package cdr_pkg:
  - pd_e enum (PD_NONE, PD_EARLY, PD_LATE).
  - Function decoding up/dn to a signed vote.
  - Generic signed saturate function.
  - Default width constants: CODE_W=11, FRAC_W=8.
- Sub-module cdr_lock_det: window counter, vote sum, good-window count, locked and win_done. It takes clk, rst, an enable (= !freeze) and pd.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with up=1 → code=CODE_INIT (0), freq_int=0, locked=0, win_done=0 throughout.
2. Single vote: after reset, up=1 for 1 cycle then idle → next cycle freq_int=1 and code=4 (phase 1024); following idle cycle phase=1025, code=4. up=dn=1 for 10 cycles → no change.
3. Wrap/clamp with CODE_INIT=2046, one up:
   - WRAP=1 → code=2.
   - WRAP=0 → code=2047.
   - WRAP=0 at CODE_INIT=0 with one dn → code=0, freq_int=-1.
4. Integrator saturation, FREQ_W=4, KI=1: 10 consecutive ups → freq_int reaches 7 and holds; then dn → 6.
5. Lock acquire/lose:
   - Alternate up/dn each cycle for 256 cycles → win_done pulses at cycles 63/127/191/255; locked=1 at the edge after cycle 255.
   - Then 64 cycles of up only → net sum 64 > 16 → locked=0 after that window's end.
6. Freeze and hysteresis:
   - freeze=1 with up held 10 cycles → code, freq_int and window position unchanged; counting resumes on release.
   - While locked, a window with net sum 10 → locked stays 1 and the good count resets.

Source files
------------

// File: rtl/cdr_pkg.sv
// Shared types and helpers for the RX CDR loop filter and lock detector.
package cdr_pkg;

    // Default widths of the PI code and of the fraction below it.
    localparam int CDR_CODE_W = 11;
    localparam int CDR_FRAC_W = 8;

    // Bang-bang phase detector vote.
    typedef enum logic [1:0] {
        PD_NONE  = 2'd0,
        PD_EARLY = 2'd1,
        PD_LATE  = 2'd2
    } pd_e;

    // Classify an up/dn pair; coincident votes cancel.
    function automatic pd_e pd_decode(input logic up, input logic dn);
        pd_e res;
        case ({up, dn})
            2'b10:   res = PD_EARLY;
            2'b01:   res = PD_LATE;
            default: res = PD_NONE;
        endcase
        return res;
    endfunction

    // Signed vote: +1 early, -1 late, 0 otherwise.
    function automatic logic signed [1:0] pd_vote(input logic up, input logic dn);
        logic signed [1:0] v;
        case (pd_decode(up, dn))
            PD_EARLY: v = 2'sb01;
            PD_LATE:  v = 2'sb11;
            default:  v = 2'sb00;
        endcase
        return v;
    endfunction

    // Clamp a signed value symmetrically to +/-lim.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                       input logic signed [31:0] lim);
        logic signed [31:0] res;
        if (val > lim) begin
            res = lim;
        end else if (val < -lim) begin
            res = -lim;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/cdr_lock_det.sv
// Windowed vote-balance lock detector with hysteresis.
module cdr_lock_det
    import cdr_pkg::*;
#(
    parameter int WIN_LEN      = 64,
    parameter int LOCK_THR     = 4,
    parameter int UNLOCK_THR   = 16,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic signed [1:0] pd,
    output logic              locked,
    output logic              win_done
);

    localparam int CNT_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int SUM_W  = $clog2(WIN_LEN) + 2;
    localparam int GOOD_W = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;

    logic [CNT_W-1:0]         cnt_r;
    logic signed [SUM_W-1:0]  sum_r;
    logic [GOOD_W-1:0]        good_cnt_r;
    logic                     locked_r;

    logic                     last_s;
    logic signed [SUM_W-1:0]  pd_ext_s;
    logic signed [SUM_W-1:0]  sum_incl_s;
    logic [SUM_W-1:0]         mag_s;
    logic [GOOD_W-1:0]        good_next_s;
    logic                     locked_next_s;

    assign last_s     = (cnt_r == CNT_W'(WIN_LEN - 1));
    assign pd_ext_s   = {{(SUM_W - 2){pd[1]}}, pd};
    assign sum_incl_s = sum_r + pd_ext_s;
    assign mag_s      = sum_incl_s[SUM_W-1] ? -sum_incl_s : sum_incl_s;

    // Window verdict: update good-window count and lock state with hysteresis.
    always_comb begin
        good_next_s   = good_cnt_r;
        locked_next_s = locked_r;
        if (int'(mag_s) <= LOCK_THR) begin
            if (good_cnt_r < GOOD_W'(LOCK_WINDOWS)) begin
                good_next_s = good_cnt_r + GOOD_W'(1);
            end else begin
                good_next_s = good_cnt_r;
            end
        end else begin
            good_next_s = '0;
        end
        if (locked_r) begin
            if (int'(mag_s) > UNLOCK_THR) begin
                locked_next_s = 1'b0;
            end else begin
                locked_next_s = 1'b1;
            end
        end else begin
            if (good_next_s == GOOD_W'(LOCK_WINDOWS)) begin
                locked_next_s = 1'b1;
            end else begin
                locked_next_s = 1'b0;
            end
        end
    end

    // Window counter, vote accumulator and lock state; all hold when disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            sum_r      <= '0;
            good_cnt_r <= '0;
            locked_r   <= 1'b0;
        end else if (en) begin
            if (last_s) begin
                cnt_r      <= '0;
                sum_r      <= '0;
                good_cnt_r <= good_next_s;
                locked_r   <= locked_next_s;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                sum_r <= sum_incl_s;
            end
        end
    end

    assign locked   = locked_r;
    assign win_done = !rst && en && last_s;

endmodule

// File: rtl/cdr_dlf_lock.sv
// Second-order bang-bang CDR loop filter (proportional + saturating
// frequency integrator) driving the PI code, plus lock detection.
module cdr_dlf_lock
    import cdr_pkg::*;
#(
    parameter int CODE_W       = CDR_CODE_W,
    parameter int FRAC_W       = CDR_FRAC_W,
    parameter int FREQ_W       = 16,
    parameter int KP           = 4,
    parameter int KI           = 1,
    parameter int WRAP         = 1,
    parameter int CODE_INIT    = 0,
    parameter int WIN_LEN      = 64,
    parameter int LOCK_THR     = 4,
    parameter int UNLOCK_THR   = 16,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up,
    input  logic                     dn,
    input  logic                     freeze,
    output logic [CODE_W-1:0]        code,
    output logic signed [FREQ_W-1:0] freq_int,
    output logic                     locked,
    output logic                     win_done
);

    localparam int PH_W     = CODE_W + FRAC_W;
    localparam int EXT_W    = PH_W + 2;
    localparam int FREQ_LIM = (2 ** (FREQ_W - 1)) - 1;
    localparam logic signed [EXT_W-1:0] KP_STEP   = EXT_W'(KP * (2 ** FRAC_W));
    localparam logic signed [EXT_W-1:0] PHASE_MAX = $signed({2'b00, {PH_W{1'b1}}});

    logic [PH_W-1:0]          phase_acc_r;
    logic signed [FREQ_W-1:0] freq_int_r;

    logic signed [1:0]        pd_s;
    logic                     en_s;
    logic signed [EXT_W-1:0]  prop_s;
    logic signed [EXT_W-1:0]  freq_ext_s;
    logic signed [EXT_W-1:0]  sum_s;
    logic [PH_W-1:0]          phase_next_s;
    logic signed [31:0]       freq_sum_s;
    logic signed [31:0]       freq_sat_s;

    assign pd_s = pd_vote(up, dn);
    assign en_s = !freeze;

    // Next phase: proportional kick plus the current integrator, then wrap or clamp.
    always_comb begin
        case (pd_s)
            2'sb01:  prop_s = KP_STEP;
            2'sb11:  prop_s = -KP_STEP;
            default: prop_s = '0;
        endcase
        freq_ext_s = EXT_W'(freq_int_r);
        sum_s      = $signed({2'b00, phase_acc_r}) + prop_s + freq_ext_s;
        if (WRAP != 0) begin
            phase_next_s = sum_s[PH_W-1:0];
        end else if (sum_s[EXT_W-1]) begin
            phase_next_s = '0;
        end else if (sum_s > PHASE_MAX) begin
            phase_next_s = '1;
        end else begin
            phase_next_s = sum_s[PH_W-1:0];
        end
    end

    // Next integrator value, saturated symmetrically.
    always_comb begin
        case (pd_s)
            2'sb01:  freq_sum_s = 32'(freq_int_r) + KI;
            2'sb11:  freq_sum_s = 32'(freq_int_r) - KI;
            default: freq_sum_s = 32'(freq_int_r);
        endcase
        freq_sat_s = sat_signed(freq_sum_s, FREQ_LIM);
    end

    // Loop-filter state; freeze holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_acc_r <= {CODE_W'(CODE_INIT), {FRAC_W{1'b0}}};
            freq_int_r  <= '0;
        end else if (en_s) begin
            phase_acc_r <= phase_next_s;
            freq_int_r  <= FREQ_W'(freq_sat_s);
        end
    end

    assign code     = phase_acc_r[PH_W-1:FRAC_W];
    assign freq_int = freq_int_r;

    cdr_lock_det #(
        .WIN_LEN      (WIN_LEN),
        .LOCK_THR     (LOCK_THR),
        .UNLOCK_THR   (UNLOCK_THR),
        .LOCK_WINDOWS (LOCK_WINDOWS)
    ) u_lock_det (
        .clk      (clk),
        .rst      (rst),
        .en       (en_s),
        .pd       (pd_s),
        .locked   (locked),
        .win_done (win_done)
    );

endmodule
